// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART receiver: commits each frame on the
// falling edge of the receiver read strobe and tracks overflow / frame errors.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter bit DROP_BAD   = 1'b1
) (
    input  logic                  clkout,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdsig,
    input  logic                  rx_frameerr,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [7:0]            err_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_r;
    logic [DEPTH_LOG2-1:0] rptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  empty_r;
    logic                  full_r;
    logic [7:0]            rd_data_r;
    logic                  overflow_r;
    logic [7:0]            err_cnt_r;
    logic                  rdsig_q_r;
    logic                  armed_r;
    // Set once a low strobe level has really been sampled after reset, so a
    // strobe already high at reset release is not mistaken for a rising edge.
    logic                  primed_r;

    logic                  rise_s;
    logic                  commit_s;
    logic                  err_event_s;
    logic                  write_req_s;
    logic                  pop_s;
    logic                  do_write_s;
    logic                  ovf_event_s;
    logic [DEPTH_LOG2:0]   count_next_s;
    logic [DEPTH_LOG2-1:0] rptr_next_s;
    logic [DEPTH_LOG2-1:0] wptr_next_s;

    // Strobe edge detection, write/pop qualification and next occupancy.
    always_comb begin
        rise_s       = rx_rdsig & ~rdsig_q_r & primed_r;
        commit_s     = rdsig_q_r & ~rx_rdsig & armed_r;
        err_event_s  = commit_s & rx_frameerr;
        write_req_s  = commit_s & (~rx_frameerr | ~DROP_BAD);
        pop_s        = rd_en & ~empty_r;
        do_write_s   = write_req_s & (~full_r | pop_s);
        ovf_event_s  = write_req_s & full_r & ~pop_s;
        rptr_next_s  = pop_s ? (rptr_r + PTR_ONE) : rptr_r;
        wptr_next_s  = do_write_s ? (wptr_r + PTR_ONE) : wptr_r;
        count_next_s = count_r;
        case ({do_write_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clkout) begin
        if (do_write_s) begin
            mem_r[wptr_r] <= rx_data;
        end
    end

    // Strobe history and arming state.
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            rdsig_q_r <= 1'b0;
            armed_r   <= 1'b0;
            primed_r  <= 1'b0;
        end else begin
            rdsig_q_r <= rx_rdsig;
            if (!rx_rdsig) begin
                primed_r <= 1'b1;
            end
            if (rise_s) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Pointers, occupancy flags and the registered head-of-queue output.
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r    <= {DEPTH_LOG2{1'b0}};
            rptr_r    <= {DEPTH_LOG2{1'b0}};
            count_r   <= {(DEPTH_LOG2+1){1'b0}};
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            rd_data_r <= 8'h00;
        end else begin
            wptr_r  <= wptr_next_s;
            rptr_r  <= rptr_next_s;
            count_r <= count_next_s;
            empty_r <= (count_next_s == {(DEPTH_LOG2+1){1'b0}});
            full_r  <= (count_next_s == FULL_CNT);
            // Bypass when the byte being written becomes the new head.
            if (do_write_s && (wptr_r == rptr_next_s)) begin
                rd_data_r <= rx_data;
            end else begin
                rd_data_r <= mem_r[rptr_next_s];
            end
        end
    end

    // Sticky overflow and saturating error counter; a new event beats clr_err.
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            err_cnt_r  <= 8'h00;
        end else begin
            if (ovf_event_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (err_event_s) begin
                if (clr_err) begin
                    err_cnt_r <= 8'h01;
                end else if (err_cnt_r != 8'hFF) begin
                    err_cnt_r <= err_cnt_r + 8'h01;
                end
            end else if (clr_err) begin
                err_cnt_r <= 8'h00;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign empty    = empty_r;
    assign full     = full_r;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected bytes, a monitor
// compares rd_data on every accepted pop. A second instance covers DROP_BAD=0.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdsig = 1'b0;
    logic       rx_frameerr = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] rd_data, rd_data0;
    logic       empty, empty0, full, full0, overflow, overflow0;
    logic [4:0] count, count0;
    logic [7:0] err_cnt, err_cnt0;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH_LOG2(4), .DROP_BAD(1'b1)) dut (
        .clkout(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdsig(rx_rdsig),
        .rx_frameerr(rx_frameerr), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .err_cnt(err_cnt)
    );

    uart_rx_fifo #(.DEPTH_LOG2(4), .DROP_BAD(1'b0)) dut0 (
        .clkout(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdsig(rx_rdsig),
        .rx_frameerr(rx_frameerr), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(rd_data0), .empty(empty0), .full(full0), .count(count0),
        .overflow(overflow0), .err_cnt(err_cnt0)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT will accept must return the next expected byte.
    always @(negedge clk) begin
        if (rst_n && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data", rd_data);
            end else begin
                chk("pop_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; rx_rdsig = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rx_frameerr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One receiver frame: strobe high for two cycles, then falls (commit cycle).
    task automatic frame(input logic [7:0] d, input logic e, input logic p);
        @(posedge clk); #1;
        rx_rdsig = 1'b1; rx_data = d; rx_frameerr = e;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rx_rdsig = 1'b0; rd_en = p;
        @(posedge clk); #1;
        rd_en = 1'b0; rx_frameerr = 1'b0;
    endtask

    task automatic pop();
        @(posedge clk); #1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_rd_data", rd_data, 0);

        // Single frame.
        exp_q.push_back(8'h5A);
        frame(8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        chk("single_empty", empty, 0);
        chk("single_rd_data", rd_data, 8'h5A);
        chk("single_count", count, 1);
        pop();
        @(negedge clk);
        chk("single_empty_after", empty, 1);
        chk("single_count_after", count, 0);

        // Fill and overflow: 0x10 is dropped.
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            frame(8'(i), 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_overflow", overflow, 1);
        for (int i = 0; i < 16; i++) pop();
        @(negedge clk);
        chk("drain_empty", empty, 1);

        // Full with simultaneous pop and commit.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            frame(8'(8'h20 + i), 1'b0, 1'b0);
        end
        exp_q.push_back(8'hA5);
        frame(8'hA5, 1'b0, 1'b1);
        @(negedge clk);
        chk("fullpop_count", count, 16);
        chk("fullpop_overflow", overflow, 0);
        chk("fullpop_full", full, 1);
        for (int i = 0; i < 16; i++) pop();
        @(negedge clk);
        chk("fullpop_drained", empty, 1);

        // Frame errors: dropped in dut, stored in dut0.
        do_reset();
        frame(8'h33, 1'b1, 1'b0);
        @(negedge clk);
        chk("ferr_err_cnt", err_cnt, 1);
        chk("ferr_count", count, 0);
        chk("ferr0_err_cnt", err_cnt0, 1);
        chk("ferr0_count", count0, 1);
        chk("ferr0_rd_data", rd_data0, 8'h33);
        for (int i = 0; i < 300; i++) frame(8'h44, 1'b1, 1'b0);
        @(negedge clk);
        chk("ferr_saturate", err_cnt, 255);
        chk("ferr_still_empty", count, 0);
        @(posedge clk); #1; clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
        @(negedge clk);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_overflow0", overflow0, 0);

        // Asynchronous reset with data present, then reset released mid-frame.
        do_reset();
        frame(8'h11, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0; rx_rdsig = 1'b1; rx_data = 8'h77;
        #1;
        chk("async_rst_empty", empty, 1);
        chk("async_rst_count", count, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rx_rdsig = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("midframe_dropped", count, 0);
        exp_q.push_back(8'h88);
        frame(8'h88, 1'b0, 1'b0);
        @(negedge clk);
        chk("midframe_next_count", count, 1);
        chk("midframe_next_data", rd_data, 8'h88);
        pop();

        // Pointer wrap with interleaved write/read pairs.
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(8'(i));
            frame(8'(i), 1'b0, 1'b0);
            pop();
        end
        @(negedge clk);
        chk("wrap_empty", empty, 1);
        pop();
        @(negedge clk);
        chk("empty_pop_count", count, 0);
        chk("empty_pop_empty", empty, 1);
        exp_q.push_back(8'h99);
        frame(8'h99, 1'b0, 1'b0);
        @(negedge clk);
        chk("after_empty_pop_count", count, 1);
        chk("after_empty_pop_data", rd_data, 8'h99);
        pop();
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
